// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: valid/ready operand capture, registered result/zero/illegal held until accepted.
// Optional iterative shift-add multiply on code 3'b011 when ALU_EXEC_MUL_EN is defined.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic             accept;
    logic             is_mul_op;
    logic             mul_done;
    logic             signed_lt;
    logic [WIDTH-1:0] alu_value;
    logic             alu_illegal;
    logic             load_result;
    logic [WIDTH-1:0] load_value;
    logic             load_illegal;

    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign signed_lt = $signed(src_a) < $signed(src_b);

`ifdef ALU_EXEC_MUL_EN
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [CW-1:0]    mul_cnt;

    assign is_mul_op = (alu_control == 3'b011);
    assign mul_done  = (state == BUSY) && (mul_cnt == CNT_LAST);
    assign acc_next  = mplier[0] ? (acc + mcand) : acc;

    // One multiplier bit per BUSY cycle; the final partial sum goes straight into result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            mul_cnt <= '0;
        end else if (accept && is_mul_op) begin
            mcand   <= src_a;
            mplier  <= src_b;
            acc     <= '0;
            mul_cnt <= '0;
        end else if (state == BUSY) begin
            acc     <= acc_next;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            mul_cnt <= mul_cnt + 1'b1;
        end
    end
`else
    assign is_mul_op = 1'b0;
    assign mul_done  = 1'b0;
`endif

    // Single-cycle operations are evaluated directly on the accepted operands.
    always_comb begin
        alu_value   = '0;
        alu_illegal = 1'b0;
        case (alu_control)
            3'b010:  alu_value = src_a + src_b;
            3'b110:  alu_value = src_a - src_b;
            3'b000:  alu_value = src_a & src_b;
            3'b001:  alu_value = src_a | src_b;
            3'b111:  alu_value = {{(WIDTH-1){1'b0}}, signed_lt};
            default: alu_illegal = 1'b1;
        endcase
    end

    always_comb begin
        load_result  = 1'b0;
        load_value   = '0;
        load_illegal = 1'b0;
        if (accept && !is_mul_op) begin
            load_result  = 1'b1;
            load_value   = alu_value;
            load_illegal = alu_illegal;
        end
`ifdef ALU_EXEC_MUL_EN
        else if (mul_done) begin
            load_result  = 1'b1;
            load_value   = acc_next;
            load_illegal = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = is_mul_op ? BUSY : DONE;
                end
            end
            BUSY: begin
`ifdef ALU_EXEC_MUL_EN
                if (mul_done) begin
                    state_next = DONE;
                end
`else
                state_next = IDLE;
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs only change when a new result is loaded, so they hold through DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result  <= '0;
            zero    <= 1'b0;
            illegal <= 1'b0;
        end else if (load_result) begin
            result  <= load_value;
            zero    <= (load_value == '0);
            illegal <= load_illegal;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized self-checking bench for alu_exec_unit against a behavioural reference model.
// Honours ALU_EXEC_MUL_EN the same way as the design.
module tb_alu_exec_unit;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       alu_control = 3'b000;
    logic [WIDTH-1:0] src_a = '0;
    logic [WIDTH-1:0] src_b = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;

    int n_compared = 0;
    int n_mismatched = 0;

    alu_exec_unit #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .src_a       (src_a),
        .src_b       (src_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Expected result, illegal flag and accept-to-out_valid latency in cycles.
    function automatic void refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] r, output logic ill, output int lat);
        longint prod;
        r   = '0;
        ill = 1'b0;
        lat = 1;
        prod = 0;
        case (op)
            3'b010: r = a + b;
            3'b110: r = a - b;
            3'b000: r = a & b;
            3'b001: r = a | b;
            3'b111: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            3'b011: begin
`ifdef ALU_EXEC_MUL_EN
                prod = longint'({32'd0, a}) * longint'({32'd0, b});
                r    = prod[31:0];
                lat  = WIDTH + 1;
`else
                ill = 1'b1;
`endif
            end
            default: ill = 1'b1;
        endcase
    endfunction

    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int stall);
        logic [31:0] exp_r;
        logic        exp_ill;
        int          exp_lat;
        int          waited;
        int          edges;
        refModel(op, a, b, exp_r, exp_ill, exp_lat);
        @(negedge clk);
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) checkOutput("in_ready_wait", 64'(in_ready), 64'd1);
        in_valid    = 1'b1;
        alu_control = op;
        src_a       = a;
        src_b       = b;
        out_ready   = 1'b0;
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        src_a       = $urandom;
        src_b       = $urandom;
        alu_control = 3'($urandom);
        edges = 1;
        @(negedge clk);
        while (!out_valid && edges < exp_lat + 8) begin
            checkOutput("in_ready_busy", 64'(in_ready), 64'd0);
            @(negedge clk);
            edges++;
        end
        checkOutput("latency", 64'(edges), 64'(exp_lat));
        checkOutput("result", 64'(result), 64'(exp_r));
        checkOutput("zero", 64'(zero), 64'(exp_r == 32'd0));
        checkOutput("illegal", 64'(illegal), 64'(exp_ill));
        checkOutput("in_ready_done", 64'(in_ready), 64'd0);
        for (int i = 0; i < stall; i++) begin
            in_valid    = 1'($urandom_range(0, 1));
            src_a       = $urandom;
            alu_control = 3'($urandom);
            @(negedge clk);
            checkOutput("hold_valid", 64'(out_valid), 64'd1);
            checkOutput("hold_result", 64'(result), 64'(exp_r));
            checkOutput("hold_illegal", 64'(illegal), 64'(exp_ill));
            checkOutput("hold_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("release_valid", 64'(out_valid), 64'd0);
        checkOutput("release_in_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic checkReset(input string tag);
        #1;
        checkOutput({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        checkOutput({tag, "_result"}, 64'(result), 64'd0);
        checkOutput({tag, "_zero"}, 64'(zero), 64'd0);
        checkOutput({tag, "_illegal"}, 64'(illegal), 64'd0);
        checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    endtask

    // Reset while an operation is in flight, either still computing or waiting in DONE.
    task automatic midOpReset(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int wait_edges, input string tag);
        @(negedge clk);
        in_valid    = 1'b1;
        alu_control = op;
        src_a       = a;
        src_b       = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (wait_edges) @(negedge clk);
        #2;
        rst_n = 1'b0;
        checkReset(tag);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput({tag, "_post_in_ready"}, 64'(in_ready), 64'd1);
        checkOutput({tag, "_post_valid"}, 64'(out_valid), 64'd0);
    endtask

    logic [31:0] corner [8];

    initial begin
        corner[0] = 32'h0000_0000;
        corner[1] = 32'h0000_0001;
        corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'h7FFF_FFFF;
        corner[4] = 32'h8000_0000;
        corner[5] = 32'hFFFF_FFFE;
        corner[6] = 32'h0000_FFFF;
        corner[7] = 32'h5555_AAAA;

        #12;
        checkReset("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_in_ready", 64'(in_ready), 64'd1);

        applyStimulus(3'b010, 32'hFFFF_FFFF, 32'h1, 0);
        applyStimulus(3'b111, 32'hFFFF_FFFE, 32'h1, 0);
        applyStimulus(3'b111, 32'h7FFF_FFFF, 32'h8000_0000, 1);
        applyStimulus(3'b110, 32'd5, 32'd7, 4);
        applyStimulus(3'b101, 32'd3, 32'd4, 0);
        applyStimulus(3'b100, 32'd9, 32'd9, 1);
        applyStimulus(3'b011, 32'd3, 32'd4, 0);
        applyStimulus(3'b011, 32'd1234, 32'd5678, 2);
        applyStimulus(3'b000, 32'hF0, 32'h3C, 0);
        applyStimulus(3'b001, 32'hF0, 32'h0F, 0);

        midOpReset(3'b011, 32'd77, 32'd99, 3, "rst_busy");
        applyStimulus(3'b000, 32'hF0, 32'h3C, 0);
        midOpReset(3'b010, 32'd1, 32'd2, 1, "rst_done");
        applyStimulus(3'b000, 32'hF0, 32'h3C, 0);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 7)] : 32'($urandom);
            b = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 7)] : 32'($urandom);
            applyStimulus(3'($urandom_range(0, 7)), a, b, $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
